// File: rtl/sr_dmem_responder.sv
// Data-port responder for the schoolRISCV CPU: word RAM, console TX FIFO and a
// loadable cycle counter, all sharing the tri-state memData bus.
module sr_dmem_responder #(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] memAddr,
   input  logic        memWriteEnable,
   inout  wire  [31:0] memData,
   output logic [7:0]  txData,
   output logic        txValid,
   input  logic        txReady
);

   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CYCLE  = 2'd2;

   logic [31:0]   r_ram [RAM_WORDS];
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_wptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic [31:0]   r_cycle;

   logic          w_ram_sel;
   logic          w_mmio_sel;
   logic [AW-1:0] w_ram_idx;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_ovf_set;
   logic          w_ovf_clr;
   logic          w_cyc_load;
   logic [31:0]   w_status;
   logic [31:0]   w_rdata;
   logic          w_unused;

   // Region decode on the upper address bits
   assign w_ram_sel  = (memAddr[31:12] == 20'h00000);
   assign w_mmio_sel = (memAddr[31:12] == 20'h00001);
   assign w_ram_idx  = memAddr[AW+1:2];
   assign w_unused   = &{1'b0, memAddr[11:0]};

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == DEPTH_C);

   assign w_push     = memWriteEnable & w_mmio_sel & (memAddr[3:2] == REG_TXDATA);
   assign w_pop      = ~w_empty & txReady;
   // A full FIFO still takes a byte when the head leaves in the same cycle
   assign w_push_ok  = w_push & (~w_full | w_pop);
   assign w_ovf_set  = w_push & ~w_push_ok;
   assign w_ovf_clr  = memWriteEnable & w_mmio_sel & (memAddr[3:2] == REG_STATUS) & memData[2];
   assign w_cyc_load = memWriteEnable & w_mmio_sel & (memAddr[3:2] == REG_CYCLE);

   assign w_status = {24'(r_count), 5'b0, r_ovf, w_full, w_empty};

   // Zero-latency read mux
   always_comb begin
      w_rdata = '0;
      if (w_ram_sel) begin
         w_rdata = r_ram[w_ram_idx];
      end else if (w_mmio_sel) begin
         case (memAddr[3:2])
            REG_STATUS: w_rdata = w_status;
            REG_CYCLE:  w_rdata = r_cycle;
            default:    w_rdata = '0;
         endcase
      end
   end

   assign memData = memWriteEnable ? 32'bz : w_rdata;

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (memWriteEnable && w_ram_sel) begin
         r_ram[w_ram_idx] <= memData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle <= '0;
      end else if (w_cyc_load) begin
         r_cycle <= memData;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   // Console FIFO; storage cleared on reset so txData reads 0 while empty after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo[i] <= '0;
         end
      end else begin
         if (w_push_ok) begin
            r_fifo[r_wptr] <= memData[7:0];
            r_wptr         <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         if (w_push_ok && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push_ok && w_pop) begin
            r_count <= r_count - CW'(1);
         end
         r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
      end
   end

   assign txData  = r_fifo[r_rptr];
   assign txValid = ~w_empty;

endmodule

// File: tb/tb_sr_dmem_responder.sv
// Directed bench for sr_dmem_responder: RAM, console FIFO, overflow, cycle counter, reset.
module tb_sr_dmem_responder;

   logic        clk;
   logic        rst;
   logic [31:0] memAddr;
   logic        memWriteEnable;
   logic        tb_drv;
   logic [31:0] tb_wdata;
   logic        txReady;
   logic [7:0]  txData;
   logic        txValid;
   wire  [31:0] memData;

   int total;
   int bad;

   assign memData = tb_drv ? tb_wdata : 32'bz;

   sr_dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .memAddr        (memAddr),
      .memWriteEnable (memWriteEnable),
      .memData        (memData),
      .txData         (txData),
      .txValid        (txValid),
      .txReady        (txReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc_wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      memAddr = a; memWriteEnable = 1'b1; tb_drv = 1'b1; tb_wdata = d; txReady = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      memAddr = a; memWriteEnable = 1'b0; tb_drv = 1'b0; txReady = 1'b0;
      #1 chk(tag, memData, exp);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      @(negedge clk);
      memWriteEnable = 1'b0; tb_drv = 1'b0; txReady = 1'b1;
      #1;
      chk({tag, "_valid"}, 32'(txValid), 32'd1);
      chk({tag, "_data"}, 32'(txData), 32'(exp));
   endtask

   task automatic chk_empty(input string tag);
      @(negedge clk);
      memWriteEnable = 1'b0; tb_drv = 1'b0; txReady = 1'b0;
      #1 chk(tag, 32'(txValid), 32'd0);
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; memAddr = '0; memWriteEnable = 1'b0; tb_drv = 1'b0;
      tb_wdata = '0; txReady = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      memAddr = 32'h1008;
      #1;
      chk("rst_txvalid", 32'(txValid), 32'd0);
      chk("rst_txdata", 32'(txData), 32'd0);
      chk("rst_cycle", memData, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("rst_status", 32'h1004, 32'h0000_0001);

      // RAM write, read-back, alias and unmapped regions
      cyc_wr(32'h0008, 32'hDEAD_BEEF);
      rd_chk("ram_rd", 32'h0008, 32'hDEAD_BEEF);
      rd_chk("ram_alias", 32'h0108, 32'hDEAD_BEEF);
      rd_chk("unmapped", 32'h2008, 32'h0);
      rd_chk("txdata_rd", 32'h1000, 32'h0);
      rd_chk("reg_0c_rd", 32'h100C, 32'h0);

      // console stream with backpressure
      cyc_wr(32'h1000, 32'h41);
      cyc_wr(32'h1000, 32'h42);
      cyc_wr(32'h1000, 32'h43);
      rd_chk("bp_status", 32'h1004, 32'h0000_0300);
      chk("bp_data0", 32'(txData), 32'h41);
      chk("bp_valid0", 32'(txValid), 32'd1);
      rd_chk("bp_status2", 32'h1004, 32'h0000_0300);
      chk("bp_hold", 32'(txData), 32'h41);
      pop_expect("drain_a0", 8'h41);
      pop_expect("drain_a1", 8'h42);
      pop_expect("drain_a2", 8'h43);
      chk_empty("drain_a_empty");
      rd_chk("drain_a_status", 32'h1004, 32'h0000_0001);

      // overflow and clear
      for (int i = 0; i < 5; i++) cyc_wr(32'h1000, 32'h11 + 32'(i));
      rd_chk("ovf_status", 32'h1004, 32'h0000_0406);
      cyc_wr(32'h1004, 32'h4);
      rd_chk("ovf_cleared", 32'h1004, 32'h0000_0402);
      pop_expect("drain_b0", 8'h11);
      pop_expect("drain_b1", 8'h12);
      pop_expect("drain_b2", 8'h13);
      pop_expect("drain_b3", 8'h14);
      chk_empty("drain_b_empty");

      // full with simultaneous push and pop
      for (int i = 0; i < 4; i++) cyc_wr(32'h1000, 32'h21 + 32'(i));
      @(negedge clk);
      memAddr = 32'h1000; memWriteEnable = 1'b1; tb_drv = 1'b1; tb_wdata = 32'h55;
      txReady = 1'b1;
      #1 chk("pp_head", 32'(txData), 32'h21);
      rd_chk("pp_status", 32'h1004, 32'h0000_0402);
      pop_expect("drain_c0", 8'h22);
      pop_expect("drain_c1", 8'h23);
      pop_expect("drain_c2", 8'h24);
      pop_expect("drain_c3", 8'h55);
      chk_empty("drain_c_empty");

      // cycle counter load and wrap
      cyc_wr(32'h1008, 32'hFFFF_FFFE);
      rd_chk("cyc_n1", 32'h1008, 32'hFFFF_FFFE);
      rd_chk("cyc_n2", 32'h1008, 32'hFFFF_FFFF);
      rd_chk("cyc_n3", 32'h1008, 32'h0000_0000);

      // reset mid-transfer
      cyc_wr(32'h1000, 32'h61);
      cyc_wr(32'h1000, 32'h62);
      cyc_wr(32'h1000, 32'h63);
      @(negedge clk);
      memWriteEnable = 1'b0; tb_drv = 1'b0; memAddr = 32'h1008;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(txValid), 32'd0);
      chk("mid_rst_data", 32'(txData), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("cyc_restart0", memData, 32'd0);
      rd_chk("cyc_restart1", 32'h1008, 32'd1);
      rd_chk("post_rst_status", 32'h1004, 32'h0000_0001);
      rd_chk("post_rst_ram", 32'h0008, 32'hDEAD_BEEF);

      // during a write the block releases the bus (counter is nonzero here)
      @(negedge clk);
      memAddr = 32'h1008; memWriteEnable = 1'b1; tb_drv = 1'b1; tb_wdata = 32'h0;
      #1 chk("bus_release", memData, 32'h0);
      rd_chk("cyc_load0", 32'h1008, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sr_dmem_responder.md
Name: sr_dmem_responder

Overview:
- Data-memory-side responder for the schoolRISCV CPU's data port: memAddr, memWriteEnable and the shared inout memData bus.
- Contains a word RAM with combinational read and synchronous write.
- Contains a memory-mapped console TX FIFO. Its byte stream leaves the block on a valid/ready handshake.
- Contains a free-running cycle counter that software can load.
- Sits at top level beside the CPU, in place of a plain data RAM.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, at least 4.
- FIFO_DEPTH, 4, console FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- memAddr  in  32  byte address from the CPU.
- memWriteEnable  in  1  write strobe from the CPU; it drives memData in that cycle.
- memData  inout  32  write data in; read data out.
- txData  out  8  console byte at the FIFO head.
- txValid  out  1  FIFO is not empty.
- txReady  in  1  sink accepts txData this cycle.

Behaviour:
- Reset: asynchronous and active-high. It applies to the reset-value bullet below only.
- Reset values:
  - FIFO empty: read pointer, write pointer and count are 0.
  - txValid=0, txData=0.
  - overflow flag 0, cycle counter 0.
  - RAM contents are not reset.
- Address decode uses memAddr[31:12]:
  - 0x00000: RAM region. Word index is memAddr[log2(RAM_WORDS)+1:2]; higher bits in the region alias. memAddr[1:0] is ignored.
  - 0x00001: MMIO region, decoded on memAddr[3:2] (list below).
  - Any other value: reads return 0, writes are ignored.
- MMIO registers:
  - 0x1000 TXDATA. Write pushes memData[7:0]. Read returns 0.
  - 0x1004 STATUS. Read returns {count zero-extended in [31:8], 5'b0, overflow[2], full[1], empty[0]}. Writing with memData[2]=1 clears overflow.
  - 0x1008 CYCLE. Read returns the current counter value. Write loads the counter.
  - 0x100C reads 0, writes ignored.
- Read timing:
  - When memWriteEnable=0, memData is driven combinationally from memAddr with zero latency. The CPU samples it in the same cycle.
  - When memWriteEnable=1, memData is tri-stated (high impedance).
- RAM write: on the posedge where memWriteEnable=1 and the address is in the RAM region, the selected word takes memData. A read of that word in the next cycle returns the new value.
- Cycle counter:
  - 32 bits; increments by 1 every clk and wraps 0xFFFFFFFF to 0.
  - A CYCLE write at edge N loads the written value V instead of incrementing. A read in cycle N+1 returns V; cycle N+2 returns V+1.
- FIFO push: a TXDATA write is a push request.
- FIFO pop: occurs when txValid & txReady.
- Push accept rule: a push is accepted when count<FIFO_DEPTH or a pop occurs in the same cycle.
  - A push that is not accepted drops the byte and sets overflow. Overflow is sticky until cleared.
  - When overflow is set and cleared in the same cycle, set wins.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the new byte enters the slot freed by the pop.
  - When empty, no pop can occur, so this is an ordinary push.
- Counters and flags:
  - Pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- TX output:
  - txData = the entry at the read pointer, registered storage with no combinational path from memData.
  - txValid = ~empty.
  - A pushed byte appears on txValid/txData in the cycle after the push edge.
- Output stability: while txValid=1 and txReady=0, txData and txValid hold stable.
- Reset mid-operation: an assertion of rst during any cycle empties the FIFO immediately; txValid falls asynchronously. Pending bytes are lost.

Test Plan:
- RAM write and read: write 0xDEADBEEF to 0x0008. Read 0x0008 next cycle -> memData=0xDEADBEEF. Read 0x0108 with RAM_WORDS=64 -> aliases to the same word, 0xDEADBEEF.
- Console stream with backpressure:
  - Push 0x41, 0x42, 0x43 with txReady=0 -> STATUS=0x00000300, txData=0x41 held stable.
  - Raise txReady -> 0x41, 0x42, 0x43 transferred on consecutive cycles, then txValid=0 and STATUS=0x00000001.
- Overflow and clear:
  - Push 5 bytes with txReady=0 and FIFO_DEPTH=4 -> fifth byte dropped, STATUS=0x00000406.
  - Write STATUS with 0x4 -> STATUS=0x00000402.
  - Drain -> bytes 1-4 only.
- Full with simultaneous push and pop: fill 4 entries, then push 0x55 while txReady=1 -> accepted, overflow stays 0, count stays 4, 0x55 emerges last.
- Cycle counter: write CYCLE=0xFFFFFFFE; reads on the next three cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Reset mid-transfer: rst asserted with 3 bytes queued -> txValid=0 immediately. After release -> STATUS=0x00000001, CYCLE restarts from 0, RAM keeps 0xDEADBEEF at 0x0008. With memWriteEnable=1, memData is high impedance from this block.
